// File: rtl/core_config.sv
// rtl/core_config.sv - core-wide sizing constants shared by the memory pipeline blocks
package core_config;

  localparam int MAX_OUTST = 4;
  // Widest requester count any DCache port arbiter instance may be built with.
  localparam int MAX_REQ = 4;

endpackage

// File: rtl/core_types.sv
// rtl/core_types.sv - shared memory-pipeline request and arbiter bookkeeping types
package core_types;

  import core_config::*;

  localparam int ARB_ID_W = $clog2(MAX_REQ);

  typedef struct packed {
    logic        ce;
    logic        uncache;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_dcache_rreq_t;

  typedef struct packed {
    logic [ARB_ID_W-1:0] id;
    logic                killed;
  } arb_entry_t;

endpackage

// File: rtl/arb_id_fifo.sv
// rtl/arb_id_fifo.sv - in-order record of which requester owns each outstanding DCache request
module arb_id_fifo
  import core_types::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  arb_entry_t push_data,
  input  logic       pop,
  input  logic       kill_all,
  output arb_entry_t head,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  arb_entry_t     mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;
  logic           push_ok;
  logic           pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Kill marks every slot; a push in the same cycle still lands live.
      if (kill_all) begin
        for (int i = 0; i < DEPTH; i++) begin
          mem[i].killed <= 1'b1;
        end
      end
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
    end
  end

endmodule

// File: rtl/dcache_port_arbiter.sv
// rtl/dcache_port_arbiter.sv - round-robin sharing of the DCache request port with in-order ack routing
module dcache_port_arbiter
  import core_types::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int MAX_OUTST = core_config::MAX_OUTST
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic [NUM_REQ-1:0]              req_valid_i,
  input  mem_dcache_rreq_t [NUM_REQ-1:0]  req_i,
  output logic [NUM_REQ-1:0]              req_ready_o,
  output logic [NUM_REQ-1:0]              ack_o,
  output mem_dcache_rreq_t                dcache_rreq_o,
  input  logic                            dcache_ready_i,
  input  logic                            dcache_ack_i,
  output logic                            busy_o,
  output logic                            proto_err_o
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]   rr_ptr;
  logic               uc_block;
  logic               proto_err_q;
  arb_entry_t         head;
  arb_entry_t         push_data;
  logic               fifo_full;
  logic               fifo_empty;
  logic               grant_en;
  logic               found;
  logic [PTR_W-1:0]   grant_idx;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] eligible;
  logic               pop;

  // Uncached accesses must see an empty pipe so they are strongly ordered.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = req_valid_i[i] && req_i[i].ce && (!req_i[i].uncache || fifo_empty);
    end
  end

  assign grant_en = !rst && !flush && dcache_ready_i && !fifo_full && !uc_block;

  // Distance k from rr_ptr is the outer loop so the nearest eligible index wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && grant_en && eligible[i] &&
            ((int'(rr_ptr) + k == i) || (int'(rr_ptr) + k - NUM_REQ == i))) begin
          found     = 1'b1;
          grant[i]  = 1'b1;
          grant_idx = PTR_W'(i);
        end
      end
    end
  end

  assign req_ready_o = grant;

  always_comb begin
    dcache_rreq_o = '0;
    if (found) begin
      dcache_rreq_o    = req_i[grant_idx];
      dcache_rreq_o.ce = 1'b1;
    end
  end

  assign pop              = dcache_ack_i && !fifo_empty;
  assign push_data.id     = ARB_ID_W'(grant_idx);
  assign push_data.killed = 1'b0;

  arb_id_fifo #(
    .DEPTH(MAX_OUTST)
  ) u_id_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (found),
    .push_data(push_data),
    .pop      (dcache_ack_i),
    .kill_all (flush),
    .head     (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_comb begin
    ack_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!rst && pop && !flush && !head.killed && head.id == ARB_ID_W'(i)) begin
        ack_o[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr      <= '0;
      uc_block    <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      if (found) begin
        rr_ptr <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
      end
      // An uncached grant needs an empty FIFO, so its pop is the next pop seen.
      if (found && req_i[grant_idx].uncache) begin
        uc_block <= 1'b1;
      end else if (pop) begin
        uc_block <= 1'b0;
      end
      if (dcache_ack_i && fifo_empty) begin
        proto_err_q <= 1'b1;
      end
    end
  end

  assign busy_o      = !fifo_empty && !rst;
  assign proto_err_o = proto_err_q && !rst;

endmodule
